// File: rtl/dram_arb_pkg.sv
// Shared defaults and tag type for the DRAM read arbiter.
// The tag identifies which requester an issued read belongs to.
package dram_arb_pkg;

    localparam int DEF_NUM_REQ         = 3;
    localparam int DEF_ADDR_WIDTH      = 18;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_MAX_OUTSTANDING = 4;

    // A single requester still needs a 1-bit tag to keep vectors legal.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAG_WIDTH = tag_width(DEF_NUM_REQ);

    typedef logic [TAG_WIDTH-1:0] tag_t;

endpackage

// File: rtl/dram_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding read.
// A push is accepted while full only when a pop happens in the same cycle.
module dram_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dram_rd_arbiter.sv
// Round-robin DRAM read arbiter with in-order return routing by tag.
// Optional per-requester grant counters are built when DRAM_ARB_PERF_EN is defined.
module dram_rd_arbiter
    import dram_arb_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          dram_en_rd,
    output logic [ADDR_WIDTH-1:0]         dram_addr_rd,
    input  logic                          dram_valid,
    input  logic [DATA_WIDTH-1:0]         dram_data_rd,
    output logic                          busy,
`ifdef DRAM_ARB_PERF_EN
    output logic [NUM_REQ*16-1:0]         grant_cnt,
`endif
    output logic                          rsp_err
);

    localparam int TW = tag_width(NUM_REQ);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [TW-1:0] last_gnt;
    logic [TW-1:0] gnt_idx;
    logic [TW-1:0] cand;
    logic [TW-1:0] head_tag;
    logic          found;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          do_pop;
    logic          can_issue;

    // A return retires the head tag, which frees a slot for a grant in the same cycle.
    assign do_pop    = dram_valid && !fifo_empty && !srst;
    assign can_issue = !srst && (!fifo_full || do_pop);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = TW'((int'(last_gnt) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        if (can_issue && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign dram_en_rd   = |gnt;
    assign dram_addr_rd = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign busy         = !srst && (fifo_count != '0);

    dram_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (TW)
    ) u_tag_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (dram_en_rd),
        .pop   (do_pop),
        .din   (gnt_idx),
        .dout  (head_tag),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            last_gnt  <= TW'(NUM_REQ - 1);
        end else begin
            rsp_valid <= '0;
            if (do_pop) begin
                rsp_valid[head_tag] <= 1'b1;
                rsp_data            <= dram_data_rd;
            end
            // A return with nothing outstanding has no owner; flag it until reset.
            if (dram_valid && fifo_empty) begin
                rsp_err <= 1'b1;
            end
            if (dram_en_rd) begin
                last_gnt <= gnt_idx;
            end
        end
    end

`ifdef DRAM_ARB_PERF_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
        logic [15:0] cnt;
        always_ff @(posedge clk) begin
            if (srst) begin
                cnt <= '0;
            end else if (gnt[i] && (cnt != 16'hFFFF)) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign grant_cnt[i*16 +: 16] = cnt;
    end
`endif

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Randomized bench for dram_rd_arbiter against a queue-based reference model,
// plus directed scenarios with literal expectations.
module tb_dram_rd_arbiter;

    localparam int NR = 3;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int MO = 4;

    logic              clk = 1'b0;
    logic              srst;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              dram_en_rd;
    logic [AW-1:0]     dram_addr_rd;
    logic              dram_valid;
    logic [DW-1:0]     dram_data_rd;
    logic              busy;
    logic              rsp_err;
`ifdef DRAM_ARB_PERF_EN
    logic [NR*16-1:0]  grant_cnt;
`endif

    always #5 clk = ~clk;

    dram_rd_arbiter #(
        .NUM_REQ         (NR),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .req          (req),
        .req_addr     (req_addr),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .dram_en_rd   (dram_en_rd),
        .dram_addr_rd (dram_addr_rd),
        .dram_valid   (dram_valid),
        .dram_data_rd (dram_data_rd),
        .busy         (busy),
`ifdef DRAM_ARB_PERF_EN
        .grant_cnt    (grant_cnt),
`endif
        .rsp_err      (rsp_err)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model: outstanding owners in issue order, pointer, sticky error
    int            m_tags[$];
    int            m_last = NR - 1;
    bit            m_err  = 1'b0;
    logic [NR-1:0] m_rv   = '0;
    logic [DW-1:0] m_data = '0;

    // DRAM stand-in: scheduled return cycles, in issue order
    int ret_t[$];
    bit dram_hold = 1'b0;
    bit force_dv  = 1'b0;
    int lat_lo    = 2;
    int lat_hi    = 2;
    bit rand_req  = 1'b0;
    int p_rst     = 0;

    logic [NR-1:0] s_gnt;
    logic [AW-1:0] s_addr;
    logic [NR-1:0] s_rv;
    logic [DW-1:0] s_data;
    logic          s_err;
    logic          s_busy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic [NR-1:0] mg;
        int            midx;
        int            t;
        logic [AW-1:0] maddr;
        dram_valid = 1'b0;
        if (force_dv) begin
            dram_valid   = 1'b1;
            dram_data_rd = $urandom;
            force_dv     = 1'b0;
        end else if (!dram_hold && ret_t.size() > 0 && ret_t[0] <= cyc) begin
            ret_t.delete(0);
            dram_valid   = 1'b1;
            dram_data_rd = $urandom;
        end
        mg   = '0;
        midx = 0;
        if (!srst && (m_tags.size() < MO || dram_valid)) begin
            for (int k = 1; k <= NR; k++) begin
                int c;
                c = (m_last + k) % NR;
                if (mg == '0 && req[c]) begin
                    mg[c] = 1'b1;
                    midx  = c;
                end
            end
        end
        maddr = req_addr[midx*AW +: AW];

        @(negedge clk);
        s_gnt  = gnt;
        s_addr = dram_addr_rd;
        chk("gnt", 64'(gnt), 64'(mg));
        chk("dram_en_rd", 64'(dram_en_rd), 64'(|mg));
        if (mg != '0) chk("dram_addr_rd", 64'(dram_addr_rd), 64'(maddr));

        @(posedge clk);
        if (srst) begin
            m_tags.delete();
            m_last = NR - 1;
            m_err  = 1'b0;
            m_rv   = '0;
            m_data = '0;
        end else begin
            m_rv = '0;
            if (dram_valid) begin
                if (m_tags.size() > 0) begin
                    m_rv[m_tags[0]] = 1'b1;
                    m_data          = dram_data_rd;
                    m_tags.delete(0);
                end else begin
                    m_err = 1'b1;
                end
            end
            if (mg != '0) begin
                m_tags.push_back(midx);
                m_last = midx;
                t = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (ret_t.size() > 0 && t <= ret_t[$]) t = ret_t[$] + 1;
                ret_t.push_back(t);
            end
        end
        cyc++;
        #1;
        s_rv   = rsp_valid;
        s_data = rsp_data;
        s_err  = rsp_err;
        s_busy = busy;
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        chk("rsp_data", 64'(rsp_data), 64'(m_data));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
        chk("busy", 64'(busy), 64'(!srst && m_tags.size() != 0));

        if (rand_req) begin
            for (int i = 0; i < NR; i++) begin
                if (mg[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else req_addr[i*AW +: AW] = AW'($urandom);
                end else if (!req[i] && $urandom_range(99, 0) < 40) begin
                    req[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom);
                end
            end
            if (p_rst > 0) srst = ($urandom_range(999, 0) < p_rst);
        end
    endtask

    task automatic do_reset();
        srst = 1'b1;
        req  = '0;
        ret_t.delete();
        dram_hold = 1'b0;
        step();
        step();
        srst = 1'b0;
    endtask

    initial begin
        srst         = 1'b1;
        req          = '0;
        req_addr     = '0;
        dram_valid   = 1'b0;
        dram_data_rd = '0;
        @(posedge clk);
        #1;

        // reset state
        do_reset();
        chk("reset_rsp_valid", 64'(s_rv), 64'(0));
        chk("reset_rsp_data", 64'(s_data), 64'(0));
        chk("reset_busy", 64'(s_busy), 64'(0));

        // all three requesting, fixed 2-cycle DRAM latency
        lat_lo = 2; lat_hi = 2;
        req = 3'b111;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("s1_gnt_order", 64'(s_gnt), 64'(3'b001 << (i % 3)));
            if (i >= 2) chk("s1_rsp_tag", 64'(s_rv), 64'(3'b001 << ((i - 2) % 3)));
        end
        req = '0;
        for (int i = 0; i < 6; i++) step();

        // single requester streams every cycle
        do_reset();
        req_addr[1*AW +: AW] = 18'h00100;
        req = 3'b010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("s2_gnt", 64'(s_gnt), 64'(3'b010));
            chk("s2_addr", 64'(s_addr), 64'(18'h00100));
        end
        req = '0;
        for (int i = 0; i < 6; i++) step();

        // DRAM stalled until four reads are outstanding
        do_reset();
        dram_hold = 1'b1;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s3_fill_gnt", 64'(s_gnt), 64'(3'b001 << (i % 3)));
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk("s3_stall_gnt", 64'(s_gnt), 64'(0));
            chk("s3_stall_busy", 64'(s_busy), 64'(1));
        end
        dram_hold = 1'b0;
        step();
        chk("s3_swap_gnt", 64'(s_gnt), 64'(3'b010));
        chk("s3_swap_rsp", 64'(s_rv), 64'(3'b001));
        chk("s3_swap_busy", 64'(s_busy), 64'(1));
        req = '0;
        for (int i = 0; i < 8; i++) step();
        chk("s3_drained_busy", 64'(s_busy), 64'(0));

        // return with nothing outstanding
        do_reset();
        force_dv = 1'b1;
        step();
        chk("s4_no_rsp", 64'(s_rv), 64'(0));
        chk("s4_err", 64'(s_err), 64'(1));
        for (int i = 0; i < 3; i++) step();
        chk("s4_err_sticky", 64'(s_err), 64'(1));
        srst = 1'b1;
        step();
        chk("s4_err_cleared", 64'(s_err), 64'(0));
        srst = 1'b0;

        // reset with three reads in flight
        do_reset();
        lat_lo = 1; lat_hi = 1;
        dram_hold = 1'b1;
        req = 3'b111;
        for (int i = 0; i < 3; i++) step();
        srst = 1'b1;
        step();
        chk("s5_gnt_forced", 64'(s_gnt), 64'(0));
        chk("s5_rsp_valid", 64'(s_rv), 64'(0));
        chk("s5_rsp_data", 64'(s_data), 64'(0));
        chk("s5_busy", 64'(s_busy), 64'(0));
        req = '0;
        srst = 1'b0;
        dram_hold = 1'b0;
        step();
        chk("s5_late_err", 64'(s_err), 64'(1));
        chk("s5_late_no_rsp", 64'(s_rv), 64'(0));
        step();
        step();

        // randomized traffic, varying latency including full-FIFO stalls
        do_reset();
        lat_lo = 1; lat_hi = 6;
        rand_req = 1'b1;
        for (int i = 0; i < 1500; i++) step();
        p_rst = 5;
        for (int i = 0; i < 1500; i++) step();
        p_rst = 0;
        rand_req = 1'b0;
        srst = 1'b0;
        req = '0;
        for (int i = 0; i < 20; i++) step();

`ifdef DRAM_ARB_PERF_EN
        do_reset();
        lat_lo = 1; lat_hi = 1;
        req = 3'b001;
        for (int i = 0; i < 70000; i++) step();
        chk("s6_cnt0_sat", 64'(grant_cnt[15:0]), 64'(16'hFFFF));
        chk("s6_cnt1", 64'(grant_cnt[31:16]), 64'(0));
        chk("s6_cnt2", 64'(grant_cnt[47:32]), 64'(0));
        req = '0;
        for (int i = 0; i < 4; i++) step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_rd_arbiter.md
DRAM_RD_ARBITER -- requirements
Module: dram_rd_arbiter

Interface
REQ-001: Parameter NUM_REQ, default 3: number of read requesters (0 = image/feature, 1 = weight, 2 = bias).
REQ-002: Parameter ADDR_WIDTH, default 18: DRAM word-address width.
REQ-003: Parameter DATA_WIDTH, default 32: DRAM data width.
REQ-004: Parameter MAX_OUTSTANDING, default 4: maximum number of issued, unreturned reads.
REQ-005: clk  input  1  single clock; all logic on the rising edge.
REQ-006: srst  input  1  synchronous, active-high reset.
REQ-007: req  input  NUM_REQ  per-requester read request, held until granted.
REQ-008: req_addr  input  NUM_REQ*ADDR_WIDTH  flattened per-requester addresses; requester i occupies slice i.
REQ-009: gnt  output  NUM_REQ  one-hot grant, combinational.
REQ-010: rsp_valid  output  NUM_REQ  one-hot registered response strobe.
REQ-011: rsp_data  output  DATA_WIDTH  registered response data, shared by all requesters.
REQ-012: dram_en_rd  output  1  DRAM read enable, combinational.
REQ-013: dram_addr_rd  output  ADDR_WIDTH  DRAM read address, equal to the granted requester's address.
REQ-014: dram_valid  input  1  DRAM read-return strobe; returns arrive in issue order.
REQ-015: dram_data_rd  input  DATA_WIDTH  DRAM read-return data.
REQ-016: busy  output  1  high while the outstanding count is non-zero.
REQ-017: rsp_err  output  1  sticky error flag for an unexpected return.

Function
REQ-018: Arbitration is round-robin; search starts at last-granted+1 modulo NUM_REQ.
REQ-019: At most one gnt bit is high per cycle; gnt[i] high implies req[i] high.
REQ-020: dram_en_rd equals OR(gnt), in the same cycle as gnt; issue throughput is one read per cycle.
REQ-021: A requester seeing gnt high advances or drops req at the next edge.
REQ-022: Each grant pushes the requester index into an in-order tag FIFO of depth MAX_OUTSTANDING.
REQ-023: Each dram_valid pops the head tag; at the next edge, rsp_valid[tag] = 1 and rsp_data = dram_data_rd; otherwise rsp_valid = 0 and rsp_data holds its value.
REQ-024: Return latency to a requester is dram_valid + 1 cycle.
REQ-025: When the FIFO is full and dram_valid = 0, no grant is made; gnt = 0.
REQ-026: When the FIFO is full and dram_valid = 1 in the same cycle, grant is permitted; push and pop happen together and the count is unchanged.
REQ-027: When dram_valid = 1 with count 0, no pop and no rsp_valid occur; rsp_err is set and held until srst.
REQ-028: Simultaneous grant and return with count 0 is not a legal case (the return is treated per REQ-027).
REQ-029: The round-robin pointer updates only on a grant; with no req, the pointer holds.

Reset
REQ-030: While srst is high: the count goes to 0, the FIFO empties, the pointer goes to NUM_REQ-1 (requester 0 wins first), rsp_valid = 0, rsp_data = 0, rsp_err = 0 and busy = 0.
REQ-031: gnt and dram_en_rd are forced to 0 during srst.
REQ-032: srst mid-operation discards all in-flight tags; DRAM returns after reset deassertion with count 0 set rsp_err.

Configuration
REQ-033: Macro DRAM_ARB_PERF_EN defined: adds output grant_cnt (NUM_REQ*16), one 16-bit saturating grant counter per requester, cleared by srst.
REQ-034: Macro DRAM_ARB_PERF_EN undefined: the grant_cnt port and counters are absent; all other behaviour is identical.

Structure
REQ-035: Package dram_arb_pkg holds DEF_NUM_REQ, DEF_ADDR_WIDTH, DEF_DATA_WIDTH, DEF_MAX_OUTSTANDING, the tag width ($clog2(NUM_REQ)) and the tag typedef.
REQ-036: Sub-module dram_tag_fifo: synchronous in-order FIFO with push, pop, full, empty and count; it supports push and pop in the same cycle when full.

Verification
REQ-037: Scenario 1: req = 3'b111 held, DRAM returns 2 cycles after issue -> grants go 0,1,2,0,1,2…; each rsp_valid arrives 3 cycles after its gnt with matching data.
REQ-038: Scenario 2: only req[1] high, addr 0x00100 -> gnt[1] every cycle; dram_addr_rd = 0x00100; the pointer stays at 1.
REQ-039: Scenario 3: DRAM stalled with 4 reads outstanding -> gnt = 0 and busy = 1; in the cycle the first dram_valid arrives, one grant is issued and the count stays 4.
REQ-040: Scenario 4: dram_valid pulsed with count 0 -> no rsp_valid; rsp_err = 1 until srst.
REQ-041: Scenario 5: srst asserted with 3 outstanding -> all outputs take their reset values next cycle; the 3 late returns raise rsp_err.
REQ-042: Scenario 6 (DRAM_ARB_PERF_EN): 70000 grants to requester 0 -> grant_cnt[15:0] = 16'hFFFF saturated; the other counters read 0.
